seg7_shiftreg_tx: RTL and testbench

Serial transmitter for the 4-digit 7-segment display. It accepts one 16-bit shift-register frame from the 4x7seg encoder via a valid/ready handshake and shifts it MSB-first into the external 74HC595-style chain. It then pulses the storage latch, advances the digit-scan index that feeds the encoder, and repeats, multiplexing the display.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_shiftreg_tx_if.sv | 11 +
 rtl/seg7_shiftreg_tx.sv | 88 ++++++++
 tb/tb_seg7_shiftreg_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit 7-segment display path (encoder and
// serial transmitter).
package seg7_pkg;
  localparam int FRAME_BITS = 16;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);
  localparam int BITCNT_W   = $clog2(FRAME_BITS);

  // Frame layout: segments a..g in [6:0], colon in [7], digit anodes in [11:8].
  localparam int SEG_LSB     = 0;
  localparam int COLON_BIT   = 7;
  localparam int ANODE_LSB   = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } tx_state_e;

  function automatic int anode_bit(input int digit);
    return ANODE_LSB + digit;
  endfunction
endpackage

// File: rtl/seg7_shiftreg_tx_if.sv
// Frame handshake between the 4x7seg encoder (master) and the serial
// transmitter (slave).
interface seg7_shiftreg_tx_if;
  import seg7_pkg::*;
  logic [FRAME_BITS-1:0] frame_i;
  logic                  frame_valid_i;
  logic                  frame_ready_o;

  modport master (output frame_i, output frame_valid_i, input frame_ready_o);
  modport slave  (input frame_i, input frame_valid_i, output frame_ready_o);
endinterface

// File: rtl/seg7_shiftreg_tx.sv
// Shifts one 16-bit frame MSB-first into a 74HC595-style chain, pulses the
// storage latch, then advances the digit-scan index for the encoder.
module seg7_shiftreg_tx
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 2   // clk cycles per sr_clk half-period, 1..255
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_shiftreg_tx_if.slave  fin,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               sr_data_o,
  output logic               sr_clk_o,
  output logic               sr_latch_o,
  output logic               done_o
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  tx_state_e             state, state_nxt;
  logic [FRAME_BITS-1:0] shreg;
  logic [BITCNT_W-1:0]   bitcnt;
  logic [7:0]            div;
  logic                  xfer, div_end;
  logic                  clk_d, latch_d, ready_d, done_d;

  assign xfer    = fin.frame_valid_i & fin.frame_ready_o;
  assign div_end = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (xfer)    state_nxt = SHIFT_LO;
      SHIFT_LO: if (div_end) state_nxt = SHIFT_HI;
      SHIFT_HI: if (div_end) state_nxt = (bitcnt == '0) ? LATCH : SHIFT_LO;
      LATCH:    if (div_end) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every pin
  // changes exactly at the state transition edge.
  always_comb begin
    clk_d   = (state_nxt == SHIFT_HI);
    latch_d = (state_nxt == LATCH);
    ready_d = (state_nxt == IDLE);
    done_d  = (state == LATCH) && div_end;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg             <= '0;
      bitcnt            <= '0;
      div               <= '0;
      digit_o           <= '0;
      sr_data_o         <= 1'b0;
      sr_clk_o          <= 1'b0;
      sr_latch_o        <= 1'b0;
      done_o            <= 1'b0;
      fin.frame_ready_o <= 1'b1;
    end else begin
      sr_clk_o          <= clk_d;
      sr_latch_o        <= latch_d;
      done_o            <= done_d;
      fin.frame_ready_o <= ready_d;

      if (xfer || (state != IDLE && div_end)) div <= '0;
      else if (state != IDLE)                 div <= div + 8'd1;

      // sr_data_o only moves on SHIFT_LO entry: full half-period setup and hold.
      if (xfer) begin
        shreg     <= fin.frame_i;
        bitcnt    <= BITCNT_W'(FRAME_BITS - 1);
        sr_data_o <= fin.frame_i[FRAME_BITS-1];
      end else if (state == SHIFT_HI && div_end && bitcnt != '0) begin
        shreg     <= shreg << 1;
        bitcnt    <= bitcnt - 1'b1;
        sr_data_o <= shreg[FRAME_BITS-2];
      end

      if (done_d) digit_o <= digit_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_seg7_shiftreg_tx.sv
// Scoreboard bench: two transmitters (CLK_DIV=1 and 3) share clock and reset;
// a per-DUT monitor reassembles shifted frames and checks timing.
module tb_seg7_shiftreg_tx;
  typedef struct {
    logic [15:0] frame;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  logic [1:0]       vld = '0;
  logic [1:0][15:0] frm = '0;
  logic [1:0]       rdy, sclk, sdata, lat, done;
  logic [1:0][1:0]  dig;
  logic [1:0][31:0] ndone_w, nrise_w, nlatch_w, nxfer_w;
  logic             b2b = 1'b0;

  seg7_shiftreg_tx_if if0 ();
  seg7_shiftreg_tx_if if1 ();
  assign if0.frame_i = frm[0];
  assign if0.frame_valid_i = vld[0];
  assign if1.frame_i = frm[1];
  assign if1.frame_valid_i = vld[1];
  assign rdy[0] = if0.frame_ready_o;
  assign rdy[1] = if1.frame_ready_o;

  seg7_shiftreg_tx #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .fin(if0.slave), .digit_o(dig[0]),
    .sr_data_o(sdata[0]), .sr_clk_o(sclk[0]), .sr_latch_o(lat[0]), .done_o(done[0])
  );
  seg7_shiftreg_tx #(.CLK_DIV(3)) u_div3 (
    .clk(clk), .rst_n(rst_n), .fin(if1.slave), .digit_o(dig[1]),
    .sr_data_o(sdata[1]), .sr_clk_o(sclk[1]), .sr_latch_o(lat[1]), .done_o(done[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int D = (g == 0) ? 1 : 3;
    exp_t        q[$];
    exp_t        e;
    logic [15:0] acc = '0;
    logic [1:0]  exp_dig = '0;
    logic        prev_clk = 1'b0, prev_lat = 1'b0;
    int          nbits = 0, hi_run = 0, lat_run = 0, last_t0 = 0, b2b_cnt = 0;
    int          ndone = 0, nrise = 0, nlatch = 0, nxfer = 0;

    assign ndone_w[g]  = ndone;
    assign nrise_w[g]  = nrise;
    assign nlatch_w[g] = nlatch;
    assign nxfer_w[g]  = nxfer;

    always @(posedge clk) begin
      if (rst_n && vld[g] && rdy[g]) begin
        e.frame = frm[g];
        e.t0    = cyc + 1;
        if (b2b) begin
          if (b2b_cnt > 0) chk("b2b_period", e.t0 - last_t0, 33 * D + 1);
          b2b_cnt++;
        end else b2b_cnt = 0;
        last_t0 = e.t0;
        q.push_back(e);
        nxfer++;
      end
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        nbits = 0; hi_run = 0; lat_run = 0;
        prev_clk = 1'b0; prev_lat = 1'b0; exp_dig = '0;
      end else begin
        if (sclk[g] && !prev_clk) begin
          if (q.size() == 0) chk("spurious_sr_clk", q.size(), 1);
          else chk("rise_time", cyc - q[0].t0, (2 * nbits + 1) * D);
          acc = {acc[14:0], sdata[g]};
          nbits++;
          nrise++;
        end
        if (sclk[g]) hi_run++;
        else if (prev_clk) begin
          chk("sr_clk_high_len", hi_run, D);
          hi_run = 0;
        end
        if (lat[g]) lat_run++;
        if (lat[g] && !prev_lat) nlatch++;
        if (done[g]) begin
          if (q.size() == 0) chk("spurious_done", q.size(), 1);
          else begin
            e = q.pop_front();
            exp_dig = exp_dig + 2'd1;
            chk("frame_bits", acc, e.frame);
            chk("bit_count", nbits, 16);
            chk("latch_len", lat_run, D);
            chk("done_time", cyc - e.t0, 33 * D);
            chk("digit", dig[g], exp_dig);
          end
          ndone++;
          nbits = 0;
          lat_run = 0;
        end
        prev_clk = sclk[g];
        prev_lat = lat[g];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int g, input logic [15:0] f);
    int n = 0;
    vld[g] = 1'b1;
    frm[g] = f;
    while (!rdy[g] && n < 500) begin tick(); n++; end
    chk("ready_wait", rdy[g], 1);
    tick();
    vld[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int target, input int budget);
    int n = 0;
    while (ndone_w[g] < target && n < budget) begin tick(); n++; end
    chk("done_wait", ndone_w[g], target);
  endtask

  logic [15:0] pat [5] = '{16'h1111, 16'h8001, 16'hFEDC, 16'h0F0F, 16'h7E81};

  initial begin
    int n, sent, start, d, x, base, lat_base;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int g = 0; g < 2; g++) begin
      chk("rst_ready", rdy[g], 1);
      chk("rst_digit", dig[g], 0);
      chk("rst_sr_data", sdata[g], 0);
      chk("rst_sr_clk", sclk[g], 0);
      chk("rst_latch", lat[g], 0);
      chk("rst_done", done[g], 0);
    end
    repeat (10) tick();
    chk("idle_no_sr_clk", nrise_w[0] + nrise_w[1], 0);

    // single frame, CLK_DIV=1
    send(0, 16'hA5C3);
    wait_done(0, 1, 100);

    // back-to-back with valid held high
    start = nxfer_w[0];
    d = ndone_w[0];
    sent = 0;
    n = 0;
    b2b = 1'b1;
    frm[0] = pat[0];
    vld[0] = 1'b1;
    while (sent < 5 && n < 1000) begin
      tick();
      n++;
      if (nxfer_w[0] - start > sent) begin
        sent++;
        if (sent < 5) frm[0] = pat[sent];
        else vld[0] = 1'b0;
      end
    end
    wait_done(0, d + 5, 200);
    b2b = 1'b0;
    chk("b2b_xfers", nxfer_w[0] - start, 5);

    // frame_i churn while busy
    d = ndone_w[0];
    x = nxfer_w[0];
    send(0, 16'h3C96);
    n = 0;
    while (ndone_w[0] == d && n < 200) begin frm[0] = ~frm[0]; tick(); n++; end
    chk("stab_done", ndone_w[0], d + 1);
    chk("stab_xfers", nxfer_w[0], x + 1);

    // divider, CLK_DIV=3
    send(1, 16'h5A0F);
    wait_done(1, 1, 400);

    // reset after the 5th shift clock
    base = nrise_w[0];
    send(0, 16'hFFFF);
    n = 0;
    while (nrise_w[0] < base + 5 && n < 100) begin tick(); n++; end
    chk("abort_rise_wait", nrise_w[0], base + 5);
    lat_base = nlatch_w[0];
    rst_n = 1'b0;
    tick();
    chk("abort_sr_clk", sclk[0], 0);
    chk("abort_latch", lat[0], 0);
    chk("abort_digit", dig[0], 0);
    chk("abort_ready", rdy[0], 1);
    chk("abort_digit_div3", dig[1], 0);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("abort_no_latch", nlatch_w[0], lat_base);

    // recovery after abort
    d = ndone_w[0];
    send(0, 16'h1234);
    wait_done(0, d + 1, 100);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
